// File: rtl/pack.sv
// pack: serial-to-parallel stage. Collects ARGD consecutive ARGW-bit items from a
// strobe/ready stream and emits them as one ARGD*ARGW-bit word, lane 0 first.
// Full throughput: one item per cycle in, back-to-back words out with no bubbles.
//
// Optional build macro PACK_LAST_EN adds the inp_lst port. An accepted item with
// inp_lst=1 completes a short word early, and every lane above it is zero-padded.
module pack #(
    parameter int unsigned ARGW = 8,
    parameter int unsigned ARGD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inp_stb,
    input  logic [ARGW-1:0]      inp_dat,
`ifdef PACK_LAST_EN
    input  logic                 inp_lst,
`endif
    output logic                 inp_rdy,
    output logic                 out_stb,
    output logic [ARGD*ARGW-1:0] out_dat,
    input  logic                 out_rdy
);

    localparam int unsigned IW = (ARGD > 1) ? $clog2(ARGD) : 1;
    localparam int unsigned AW = (ARGD - 1) * ARGW;
    localparam int unsigned OW = ARGD * ARGW;
    localparam logic [IW-1:0] END = IW'(ARGD - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          out_stb_q, out_stb_d;
    logic [OW-1:0] out_dat_q, out_dat_d;

    logic          lst;
    logic          inp_ack;
    logic          out_ack;
    logic          complete;
    logic [OW-1:0] acc_ext;
    logic [OW-1:0] word;

`ifdef PACK_LAST_EN
    assign lst = inp_lst;
`else
    assign lst = 1'b0;
`endif

    // Items below END only need free acc space; a completing item needs the output
    // register to be free or draining this same cycle (out_rdy -> inp_rdy is combinational).
    assign inp_rdy  = ((idx_q != END) & ~lst) | ~out_stb_q | out_rdy;
    assign inp_ack  = inp_stb & inp_rdy;
    assign out_ack  = out_stb_q & out_rdy;
    assign complete = inp_ack & ((idx_q == END) | lst);

    // acc widened by one zero lane so lane END indexes cleanly
    assign acc_ext = {{ARGW{1'b0}}, acc_q};

    // Word to publish on completion: stored lanes below idx, the incoming item at idx,
    // and zeros above it (only reachable for an early completion).
    always_comb begin
        word = '0;
        for (int j = 0; j < int'(ARGD); j++) begin
            if (IW'(j) < idx_q) begin
                word[j*ARGW +: ARGW] = acc_ext[j*ARGW +: ARGW];
            end else if (IW'(j) == idx_q) begin
                word[j*ARGW +: ARGW] = inp_dat;
            end else begin
                word[j*ARGW +: ARGW] = '0;
            end
        end
    end

    // Accumulator: write the lane at idx, clear everything on completion so a later
    // short word never picks up stale lanes as padding.
    always_comb begin
        acc_d = acc_q;
        if (complete) begin
            acc_d = '0;
        end else if (inp_ack) begin
            for (int j = 0; j < int'(ARGD) - 1; j++) begin
                if (idx_q == IW'(j)) begin
                    acc_d[j*ARGW +: ARGW] = inp_dat;
                end
            end
        end
    end

    // Lane index: advance per accepted item, wrap to lane 0 on completion.
    always_comb begin
        idx_d = idx_q;
        if (complete) begin
            idx_d = '0;
        end else if (inp_ack) begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Output register: a completion wins over a drain, giving back-to-back words.
    always_comb begin
        out_stb_d = out_stb_q;
        out_dat_d = out_dat_q;
        if (complete) begin
            out_stb_d = 1'b1;
            out_dat_d = word;
        end else if (out_ack) begin
            out_stb_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any partial or pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            out_stb_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            out_stb_q <= out_stb_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign out_stb = out_stb_q;
    assign out_dat = out_dat_q;

endmodule

// File: tb/tb_pack.sv
// tb_pack: self-checking bench for pack (ARGW=8, ARGD=4). A transaction-level model
// gathers accepted items into words and predicts out_stb, out_dat and inp_rdy each cycle.
module tb_pack;

    localparam int ARGW = 8;
    localparam int ARGD = 4;
`ifdef PACK_LAST_EN
    localparam bit LST_EN = 1'b1;
`else
    localparam bit LST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inp_stb;
    logic        inp_lst;
    logic [7:0]  inp_dat;
    logic        inp_rdy;
    logic        out_stb;
    logic [31:0] out_dat;
    logic        out_rdy;

    always #5 clk = ~clk;

    pack #(
        .ARGW(ARGW),
        .ARGD(ARGD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .inp_stb(inp_stb),
        .inp_dat(inp_dat),
`ifdef PACK_LAST_EN
        .inp_lst(inp_lst),
`endif
        .inp_rdy(inp_rdy),
        .out_stb(out_stb),
        .out_dat(out_dat),
        .out_rdy(out_rdy)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model: items gathered so far in the current word, and the pending word
    int          m_n;
    bit          m_pend;
    logic [31:0] m_word;
    logic [7:0]  m_cur[ARGD];

    logic [31:0] words[$];
    logic [7:0]  inq[$];
    logic [7:0]  outq[$];
    bit          last_in_ack;
    int          rdy_low;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit ia;
        bit oa;
        bit er;
        @(negedge clk);
        er = ((m_n != ARGD - 1) && !(LST_EN && inp_lst)) || !m_pend || out_rdy;
        check("inp_rdy", {63'd0, inp_rdy}, {63'd0, er});
        check("out_stb", {63'd0, out_stb}, {63'd0, m_pend});
        if (m_pend) check("out_dat", {32'd0, out_dat}, {32'd0, m_word});
        ia = inp_stb && inp_rdy && !rst;
        oa = out_stb && out_rdy && !rst;
        if (inp_stb && !inp_rdy) rdy_low++;
        if (oa) begin
            words.push_back(out_dat);
            for (int j = 0; j < ARGD; j++) outq.push_back(out_dat[8*j +: 8]);
        end
        if (ia) inq.push_back(inp_dat);
        last_in_ack = ia;
        @(posedge clk);
        #1;
        if (rst) begin
            m_n = 0;
            m_pend = 1'b0;
            m_word = '0;
        end else begin
            if (oa) m_pend = 1'b0;
            if (ia) begin
                m_cur[m_n] = inp_dat;
                m_n++;
                if (m_n == ARGD || (LST_EN && inp_lst)) begin
                    m_word = '0;
                    for (int j = 0; j < m_n; j++) m_word = m_word | (32'(m_cur[j]) << (8 * j));
                    m_pend = 1'b1;
                    m_n = 0;
                end
            end
        end
    endtask

    // Offer one item and hold it until accepted, with a bounded wait.
    task automatic send(input logic [7:0] d, input bit l);
        inp_stb = 1'b1;
        inp_dat = d;
        inp_lst = l;
        for (int t = 0; t < 100; t++) begin
            step();
            if (last_in_ack) break;
        end
        if (!last_in_ack) check("send_timeout", 64'd0, 64'd1);
        inp_stb = 1'b0;
        inp_lst = 1'b0;
    endtask

    initial begin
        int acc_n;
        int mism;
        rst = 1'b1;
        inp_stb = 1'b0;
        inp_lst = 1'b0;
        inp_dat = '0;
        out_rdy = 1'b0;
        rdy_low = 0;
        last_in_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_n = 0;
        m_pend = 1'b0;
        m_word = '0;
        check("rst_stb", {63'd0, out_stb}, 64'd0);
        check("rst_dat", {32'd0, out_dat}, 64'd0);
        check("rst_rdy", {63'd0, inp_rdy}, 64'd1);

        // basic pack: word appears the cycle after the last item, for a single cycle
        out_rdy = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        check("basic_stb", {63'd0, out_stb}, 64'd1);
        check("basic_dat", {32'd0, out_dat}, 64'h44332211);
        step();
        check("basic_single", {63'd0, out_stb}, 64'd0);

        // streaming: eight consecutive items, no stall expected
        words.delete();
        rdy_low = 0;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        step();
        step();
        check("stream_rdy_low", 64'(rdy_low), 64'd0);
        check("stream_nwords", 64'(words.size()), 64'd2);
        check("stream_w0", {32'd0, words[0]}, 64'h04030201);
        check("stream_w1", {32'd0, words[1]}, 64'h08070605);

        // back-pressure: pending word blocks only the END item
        words.delete();
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0);
        inp_stb = 1'b1;
        inp_dat = 8'hA3;
        repeat (3) step();
        check("bp_stall", {63'd0, inp_rdy}, 64'd0);
        check("bp_pend", {32'd0, out_dat}, 64'hB3B2B1B0);
        out_rdy = 1'b1;
        step();
        check("bp_same_cycle", {63'd0, last_in_ack}, 64'd1);
        inp_stb = 1'b0;
        check("bp_drained", {32'd0, words[0]}, 64'hB3B2B1B0);
        check("bp_next_stb", {63'd0, out_stb}, 64'd1);
        check("bp_next_dat", {32'd0, out_dat}, 64'hA3A2A1A0);
        step();

        // reset mid-word discards the partial accumulation
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_stb", {63'd0, out_stb}, 64'd0);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        check("rst_mid_dat", {32'd0, out_dat}, 64'h04030201);
        step();

`ifdef PACK_LAST_EN
        // short packet: zero-padded early completion, then a normal word
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        check("lst_stb", {63'd0, out_stb}, 64'd1);
        check("lst_dat", {32'd0, out_dat}, 64'h00002211);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        check("lst_next", {32'd0, out_dat}, 64'h04030201);
        step();
`endif

        // random throttling on both sides, 1000 items
        inq.delete();
        outq.delete();
        acc_n = 0;
        for (int cyc = 0; cyc < 20000 && acc_n < 1000; cyc++) begin
            if (!inp_stb && $urandom_range(3) != 0) begin
                inp_stb = 1'b1;
                inp_dat = 8'($urandom);
                inp_lst = LST_EN && ($urandom_range(7) == 0);
            end
            out_rdy = ($urandom_range(2) != 0);
            step();
            if (last_in_ack) begin
                acc_n++;
                inp_stb = 1'b0;
                inp_lst = 1'b0;
            end
        end
        inp_stb = 1'b0;
        inp_lst = 1'b0;
        out_rdy = 1'b1;
        repeat (4) step();
        check("rand_items", 64'(acc_n), 64'd1000);
`ifndef PACK_LAST_EN
        mism = 0;
        for (int i = 0; i < inq.size() && i < outq.size(); i++) begin
            if (inq[i] !== outq[i]) mism++;
        end
        check("loop_len", 64'(outq.size()), 64'(inq.size()));
        check("loop_seq", 64'(mism), 64'd0);
`else
        mism = 0;
        check("lst_rand_items_in", 64'(inq.size()), 64'(acc_n + mism));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pack.md
Name: pack

Overview:
- Serial-to-parallel stage; the inverse of the word splitter.
- Collects ARGD consecutive ARGW-bit items from a strobe/ready stream and emits them as one ARGD*ARGW-bit word.
- Sits upstream of the splitter, or anywhere a narrow stream must be widened for a wide-argument consumer.
- Full throughput: one item per cycle in; one word per ARGD cycles out, with no bubbles at word boundaries.

Parameters:
- ARGW, 8, width of one input item in bits.
- ARGD, 2, items per output word; legal values are >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- inp_stb  input  1  input item valid
- inp_dat  input  ARGW  input item
- inp_rdy  output  1  stage can accept an item this cycle
- out_stb  output  1  packed word valid
- out_dat  output  ARGD*ARGW  packed word
- out_rdy  input  1  downstream accepts the word
- inp_lst  input  1  last item of a short packet (present only with PACK_LAST_EN)

Behaviour:
- Transfers:
  - inp_ack = inp_stb & inp_rdy.
  - out_ack = out_stb & out_rdy.
  - Data moves only on an ack.
  - inp_stb and out_stb, once raised, are held with stable data until acked.
- Lane index:
  - idx, $clog2(ARGD) bits, with END = ARGD-1.
  - The item accepted at idx=k is written to lane k, i.e. bits [ARGW*k +: ARGW].
  - Lane 0 is the first item in, which matches the splitter's lane-0-first output order.
- Accumulator acc holds lanes 0..ARGD-2. Lane END is never stored in acc; it bypasses straight into out_dat.
- idx == END and inp_ack (word completion):
  - out_dat <= {inp_dat, acc lanes END-1..0}
  - out_stb <= 1
  - idx <= 0
- idx != END and inp_ack:
  - acc lane idx <= inp_dat
  - idx <= idx+1
- inp_rdy = (idx != END) | ~out_stb | out_rdy.
  - While idx != END, items are accepted regardless of the output register, so the next word fills while the previous one waits.
  - The combinational path out_rdy -> inp_rdy is intentional; no registered ready.
- out_stb clears on out_ack unless a completion occurs in the same cycle. Completion and drain in the same cycle: out_stb stays 1 and out_dat takes the new word (back-to-back words, zero bubbles).
- Latency: out_stb rises the cycle after the END item is accepted.
- Reset: idx=0, out_stb=0, out_dat=0, acc=0.
  - A reset mid-word discards any partial accumulation.
  - A reset while a word is pending discards that word; the first item after reset lands in lane 0.
- Back-pressure: with out_stb=1 and out_rdy=0, the stage accepts up to END items, then stalls (inp_rdy=0) at idx=END until the drain.
- Idle: with inp_stb=0 the state holds; there is no timeout.

Optional Feature:
- Macro: PACK_LAST_EN.
- Defined:
  - Adds the inp_lst port.
  - An inp_ack with inp_lst=1 at idx=k < END completes the word early:
    - lanes 0..k-1 come from acc;
    - lane k comes from inp_dat;
    - lanes k+1..END are zero;
    - out_stb <= 1 and idx <= 0.
  - For that item, inp_rdy follows the completion rule: ~out_stb | out_rdy, whatever idx is.
  - inp_lst at idx=END behaves as a normal completion.
  - acc lanes are cleared on any completion so stale data never leaks into zero padding.
- Undefined: the port is absent and words complete only at idx=END.

Test Plan (ARGW=8, ARGD=4 unless stated):
- Basic pack: feed 0x11,0x22,0x33,0x44 with out_rdy=1 -> out_stb=1 one cycle after the 0x44 ack, out_dat=0x44332211, single cycle.
- Streaming: 8 items 0x01..0x08 on consecutive cycles, out_rdy=1 -> inp_rdy never low; words 0x04030201 then 0x08070605.
- Back-pressure: out_rdy=0 after the first word; feed 0xA0..0xA3 -> three items accepted, inp_rdy=0 at idx=3. Raise out_rdy -> the first word drains and 0xA3 is accepted in the same cycle; next word 0xA3A2A1A0.
- Reset mid-word: accept 0x55,0x66, assert rst one cycle, then feed 0x01..0x04 -> out_stb=0 during and after reset until completion; word 0x04030201.
- Loopback with ARGD=2: pack output to splitter input with random stb/rdy throttling over 1000 items -> splitter output sequence identical to pack input.
- PACK_LAST_EN: 0x11,0x22 with inp_lst=1 on 0x22 -> out_dat=0x00002211; next items 0x01..0x04 -> 0x04030201.
